// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the PE16 bit-serial op sequencer.
// The PE sees the phase codes defined here on its state input.
package pe_seq_pkg;

    localparam int DEF_MAX_WORD_LENGTH = 32;
    localparam int DEF_ADDR_W          = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_MOVE_R,
        S_MOVE_W,
        S_EXEC_R,
        S_EXEC_W
    } seq_state_e;

    localparam logic [2:0] CODE_IDLE   = 3'd0;
    localparam logic [2:0] CODE_SETUP  = 3'd1;
    localparam logic [2:0] CODE_MOVE   = 3'd2;
    localparam logic [2:0] CODE_EXEC_R = 3'd3;
    localparam logic [2:0] CODE_EXEC_W = 3'd4;

    localparam logic [3:0] OP_MOVE_E = 4'hC;
    localparam logic [3:0] OP_MOVE_W = 4'hD;
    localparam logic [3:0] OP_MOVE_S = 4'hE;
    localparam logic [3:0] OP_MOVE_N = 4'hF;

    function automatic logic isMoveOp(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

    // Both move phases report code 2 so the PE keeps Booth latching disabled.
    function automatic logic [2:0] stateCode(input seq_state_e s);
        logic [2:0] code;
        case (s)
            S_SETUP:            code = CODE_SETUP;
            S_MOVE_R, S_MOVE_W: code = CODE_MOVE;
            S_EXEC_R:           code = CODE_EXEC_R;
            S_EXEC_W:           code = CODE_EXEC_W;
            default:            code = CODE_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/pe_seq_addr_gen.sv
// Per-bit BRAM address generation: base + bit index, wrapping modulo 2^ADDR_W.
module pe_seq_addr_gen
    import pe_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int IDX_W  = 8
) (
    input  logic [ADDR_W-1:0] srcA_i,
    input  logic [ADDR_W-1:0] srcB_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [IDX_W-1:0]  bitIdx_i,
    input  logic              toDst_i,
    output logic [ADDR_W-1:0] addrA_o,
    output logic [ADDR_W-1:0] addrB_o
);

    logic [ADDR_W-1:0] offset;

    // Sums are kept at ADDR_W bits so base+i wraps silently around the BRAM.
    assign offset  = ADDR_W'(bitIdx_i);
    assign addrA_o = (toDst_i ? dst_i : srcA_i) + offset;
    assign addrB_o = srcB_i + offset;

endmodule

// File: rtl/pe_op_sequencer.sv
// Bit-serial instruction sequencer driving one PE16 (or a lockstep row of them).
// Optional feature: define PE_SEQ_STALL_EN to add a 'stall' input that freezes the sequencer.
module pe_op_sequencer
    import pe_seq_pkg::*;
#(
    parameter int MAX_WORD_LENGTH = DEF_MAX_WORD_LENGTH,
    parameter int ADDR_W          = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
`ifdef PE_SEQ_STALL_EN
    input  logic              stall,
`endif
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_src_a,
    input  logic [ADDR_W-1:0] instr_src_b,
    input  logic [ADDR_W-1:0] instr_dst,
    input  logic [5:0]        instr_len,
    output logic [3:0]        alu_op,
    output logic              wea,
    output logic              web,
    output logic [ADDR_W-1:0] addra,
    output logic [ADDR_W-1:0] addrb,
    output logic [7:0]        count,
    output logic [2:0]        state,
    output logic              east,
    output logic              west,
    output logic              south,
    output logic              north,
    output logic              done
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_WORD_LENGTH);

    seq_state_e        state_q, state_d;
    logic [7:0]        bitIdx_q, bitIdx_d;
    logic [7:0]        len_q, len_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] srcA_q, srcA_d, srcB_q, srcB_d, dst_q, dst_d;

    logic              ready_q, ready_d, done_q, done_d;
    logic              wea_q, wea_d, web_q, web_d;
    logic [ADDR_W-1:0] addra_q, addra_d, addrb_q, addrb_d;
    logic [7:0]        count_q, count_d;
    logic [2:0]        code_q, code_d;
    logic [3:0]        aluOp_q, aluOp_d;
    logic [3:0]        dirs_q, dirs_d;

    logic [7:0]        lenClamped;
    logic [ADDR_W-1:0] genA, genB;
    logic              phaseActive, writePhase, moveOp;
    logic              freeze, gateWrites;

`ifdef PE_SEQ_STALL_EN
    logic stall_q;

    // Holding one extra cycle after stall drops replays the frozen cycle with its writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_q <= 1'b0;
        else        stall_q <= stall;
    end

    assign freeze     = stall | stall_q;
    assign gateWrites = stall;
`else
    assign freeze     = 1'b0;
    assign gateWrites = 1'b0;
`endif

    assign lenClamped = ({2'b00, instr_len} > MAX_LEN) ? MAX_LEN : {2'b00, instr_len};

    always_comb begin
        state_d  = state_q;
        bitIdx_d = bitIdx_q;
        len_d    = len_q;
        op_d     = op_q;
        srcA_d   = srcA_q;
        srcB_d   = srcB_q;
        dst_d    = dst_q;
        done_d   = 1'b0;
        if (!freeze) begin
            case (state_q)
                S_IDLE: begin
                    if (instr_valid && ready_q) begin
                        op_d     = instr_op;
                        srcA_d   = instr_src_a;
                        srcB_d   = instr_src_b;
                        dst_d    = instr_dst;
                        len_d    = lenClamped;
                        bitIdx_d = '0;
                        state_d  = S_SETUP;
                    end
                end
                S_SETUP: begin
                    bitIdx_d = '0;
                    if (len_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = isMoveOp(op_q) ? S_MOVE_R : S_EXEC_R;
                    end
                end
                S_EXEC_R: state_d = S_EXEC_W;
                S_MOVE_R: state_d = S_MOVE_W;
                S_EXEC_W, S_MOVE_W: begin
                    if (bitIdx_q == len_q - 8'd1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bitIdx_d = bitIdx_q + 8'd1;
                        state_d  = (state_q == S_MOVE_W) ? S_MOVE_R : S_EXEC_R;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    pe_seq_addr_gen #(
        .ADDR_W (ADDR_W),
        .IDX_W  (8)
    ) u_addr_gen (
        .srcA_i   (srcA_d),
        .srcB_i   (srcB_d),
        .dst_i    (dst_d),
        .bitIdx_i (bitIdx_d),
        .toDst_i  (state_d == S_EXEC_W),
        .addrA_o  (genA),
        .addrB_o  (genB)
    );

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        phaseActive = state_d inside {S_MOVE_R, S_MOVE_W, S_EXEC_R, S_EXEC_W};
        writePhase  = state_d inside {S_MOVE_W, S_EXEC_W};
        moveOp      = isMoveOp(op_d);
        ready_d     = (state_d == S_IDLE) && !gateWrites;
        code_d      = stateCode(state_d);
        count_d     = phaseActive ? bitIdx_d : '0;
        addra_d     = phaseActive ? genA : '0;
        addrb_d     = phaseActive ? genB : '0;
        aluOp_d     = (state_d != S_IDLE && !moveOp) ? op_d : '0;
        wea_d       = writePhase && !gateWrites;
        web_d       = (state_d == S_MOVE_W) && !gateWrites;
        dirs_d      = '0;
        if (web_d) begin
            dirs_d[0] = (op_d == OP_MOVE_E);
            dirs_d[1] = (op_d == OP_MOVE_W);
            dirs_d[2] = (op_d == OP_MOVE_S);
            dirs_d[3] = (op_d == OP_MOVE_N);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            bitIdx_q <= '0;
            len_q    <= '0;
            op_q     <= '0;
            srcA_q   <= '0;
            srcB_q   <= '0;
            dst_q    <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            wea_q    <= 1'b0;
            web_q    <= 1'b0;
            addra_q  <= '0;
            addrb_q  <= '0;
            count_q  <= '0;
            code_q   <= CODE_IDLE;
            aluOp_q  <= '0;
            dirs_q   <= '0;
        end else begin
            state_q  <= state_d;
            bitIdx_q <= bitIdx_d;
            len_q    <= len_d;
            op_q     <= op_d;
            srcA_q   <= srcA_d;
            srcB_q   <= srcB_d;
            dst_q    <= dst_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            wea_q    <= wea_d;
            web_q    <= web_d;
            addra_q  <= addra_d;
            addrb_q  <= addrb_d;
            count_q  <= count_d;
            code_q   <= code_d;
            aluOp_q  <= aluOp_d;
            dirs_q   <= dirs_d;
        end
    end

    assign instr_ready = ready_q;
    assign done        = done_q;
    assign wea         = wea_q;
    assign web         = web_q;
    assign addra       = addra_q;
    assign addrb       = addrb_q;
    assign count       = count_q;
    assign state       = code_q;
    assign alu_op      = aluOp_q;
    assign east        = dirs_q[0];
    assign west        = dirs_q[1];
    assign south       = dirs_q[2];
    assign north       = dirs_q[3];

endmodule
